// File: rtl/bcd_countdown_timer.sv
// Presettable packed-BCD down-counter with run/pause control and expiry flag.
// Shares the BCD up-counter's nibble layout so the 7-seg decode path is reused.
module bcd_countdown_timer #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start_stop,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                done,
  output logic                expired
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_e;

  state_e         state_q;
  logic [W-1:0]   count_q;
  logic [W-1:0]   reload_q;
  logic           running_q;
  logic           done_q;
  logic           expired_q;

  logic [W-1:0]   dec_d;
  logic [W-1:0]   san_d;
  logic           is_zero;
  logic           is_one;

  assign is_zero = (count_q == '0);
  assign is_one  = (count_q == W'(1));

  always_comb begin : san_blk
    san_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9)
        san_d[4*i +: 4] = 4'd9;
      else
        san_d[4*i +: 4] = load_val[4*i +: 4];
    end
  end

  // Ripple borrow: a zero digit wraps to 9 and passes the borrow upward.
  always_comb begin : dec_blk
    logic b;
    b     = 1'b1;
    dec_d = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_d[4*i +: 4] = 4'd9;
        end else begin
          dec_d[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (load) begin
        state_q   <= IDLE;
        count_q   <= san_d;
        reload_q  <= san_d;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (start_stop) begin
        unique case (state_q)
          IDLE: begin
            if (!is_zero) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            state_q   <= PAUSED;
            running_q <= 1'b0;
          end
          PAUSED: begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
          DONE: begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            count_q <= reload_q;
          end
        endcase
      end else if (tick && state_q == RUN) begin
        if (is_one) begin
          count_q   <= '0;
          state_q   <= DONE;
          running_q <= 1'b0;
          done_q    <= 1'b1;
          expired_q <= 1'b1;
        end else begin
          count_q <= dec_d;
        end
      end
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random traffic
// checked against a decimal-arithmetic reference model.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        start_stop = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] count;
  logic        running;
  logic        done;
  logic        expired;

  int nchk = 0;
  int nerr = 0;

  // model: value held as a plain decimal integer
  int m_val = 0;
  int m_rel = 0;
  int m_st  = 0; // 0 idle, 1 run, 2 paused, 3 done
  bit m_exp = 0;

  bcd_countdown_timer #(.DIGITS(4)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_val(load_val),
    .start_stop(start_stop),
    .tick(tick),
    .count(count),
    .running(running),
    .done(done),
    .expired(expired)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int san_val(input logic [15:0] lv);
    int v;
    int w;
    int d;
    v = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * w;
      w = w * 10;
    end
    return v;
  endfunction

  function automatic logic [18:0] exp_vec();
    return {to_bcd(m_val), m_st == 1, m_st == 3, m_exp};
  endfunction

  task automatic model(input bit r, l, input logic [15:0] lv,
                       input bit ss, tk);
    m_exp = 0;
    if (!r) begin
      m_val = 0; m_rel = 0; m_st = 0;
    end else if (l) begin
      m_val = san_val(lv); m_rel = m_val; m_st = 0;
    end else if (ss) begin
      case (m_st)
        0: if (m_val != 0) m_st = 1;
        1: m_st = 2;
        2: m_st = 1;
        default: begin m_st = 0; m_val = m_rel; end
      endcase
    end else if (tk && m_st == 1) begin
      m_val = m_val - 1;
      if (m_val == 0) begin m_st = 3; m_exp = 1; end
    end
  endtask

  task automatic step(input bit r, l, input logic [15:0] lv,
                      input bit ss, tk);
    reset = r; load = l; load_val = lv;
    start_stop = ss; tick = tk;
    @(posedge clk);
    model(r, l, lv, ss, tk);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 16'h0, 0, 0);
    nchk++;
    if ({count, running, done, expired} !== 19'h0) begin
      nerr++;
      $display("FAIL reset: got %h/%b%b%b want 0000/000",
               count, running, done, expired);
    end
  endtask

  task automatic test_borrow();
    logic [15:0] want [3];
    want = '{16'h0101, 16'h0100, 16'h0099};
    step(0, 0, 16'h0, 0, 0);
    step(1, 1, 16'h0102, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 16'h0, 0, 1);
      nchk++;
      if (count !== want[i] || running !== 1'b1) begin
        nerr++;
        $display("FAIL borrow tick%0d: got %h run=%b want %h run=1",
                 i, count, running, want[i]);
      end
    end
    step(1, 1, 16'h1000, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 0, 1);
    nchk++;
    if (count !== 16'h0999) begin
      nerr++;
      $display("FAIL multi_borrow: got %h want 0999", count);
    end
    step(1, 1, 16'h0000, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    nchk++;
    if (running !== 1'b0 || count !== 16'h0) begin
      nerr++;
      $display("FAIL zero_start: got %h run=%b want 0000 run=0",
               count, running);
    end
  endtask

  task automatic test_expiry();
    step(1, 1, 16'h0001, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 0, 1);
    nchk++;
    if ({count, running, done, expired} !== {16'h0, 3'b011}) begin
      nerr++;
      $display("FAIL expire_edge: got %h/%b%b%b want 0000/011",
               count, running, done, expired);
    end
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 16'h0, 0, 1);
      nchk++;
      if ({count, running, done, expired} !== {16'h0, 3'b010}) begin
        nerr++;
        $display("FAIL expire_hold%0d: got %h/%b%b%b want 0000/010",
                 i, count, running, done, expired);
      end
    end
    step(1, 0, 16'h0, 1, 0);
    nchk++;
    if ({count, running, done, expired} !== {16'h0001, 3'b000}) begin
      nerr++;
      $display("FAIL ack_reload: got %h/%b%b%b want 0001/000",
               count, running, done, expired);
    end
  endtask

  task automatic test_pause_collision();
    step(1, 1, 16'h0050, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 1, 1);
    nchk++;
    if (count !== 16'h0050 || running !== 1'b0) begin
      nerr++;
      $display("FAIL collide: got %h run=%b want 0050 run=0",
               count, running);
    end
    step(1, 0, 16'h0, 0, 1);
    step(1, 0, 16'h0, 0, 1);
    nchk++;
    if (count !== 16'h0050) begin
      nerr++;
      $display("FAIL paused_tick: got %h want 0050", count);
    end
    step(1, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 0, 1);
    nchk++;
    if (count !== 16'h0049 || running !== 1'b1) begin
      nerr++;
      $display("FAIL resume: got %h run=%b want 0049 run=1",
               count, running);
    end
  endtask

  task automatic test_sanitize();
    step(1, 1, 16'hA5F3, 1, 1);
    nchk++;
    if ({count, running, done, expired} !== {16'h9593, 3'b000}) begin
      nerr++;
      $display("FAIL sanitize: got %h/%b%b%b want 9593/000",
               count, running, done, expired);
    end
  endtask

  task automatic test_reset_midrun();
    step(1, 1, 16'h0300, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0, 0, 1);
    nchk++;
    if (count !== 16'h0295) begin
      nerr++;
      $display("FAIL pre_reset: got %h want 0295", count);
    end
    step(0, 0, 16'h0, 0, 1);
    nchk++;
    if ({count, running, done, expired} !== 19'h0) begin
      nerr++;
      $display("FAIL mid_reset: got %h/%b%b%b want 0000/000",
               count, running, done, expired);
    end
    step(1, 0, 16'h0, 1, 0);
    nchk++;
    if (running !== 1'b0 || count !== 16'h0) begin
      nerr++;
      $display("FAIL post_reset_start: got %h run=%b want 0000 run=0",
               count, running);
    end
  endtask

  task automatic test_random();
    bit r, l, ss, tk;
    logic [15:0] lv;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 59) != 0);
      l  = ($urandom_range(0, 19) == 0);
      ss = ($urandom_range(0, 7) == 0);
      tk = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1)
        lv = 16'($urandom_range(0, 40));
      else
        lv = 16'($urandom);
      step(r, l, lv, ss, tk);
      nchk++;
      if ({count, running, done, expired} !== exp_vec()) begin
        nerr++;
        $display("FAIL random%0d: got %h/%b%b%b want %h",
                 i, count, running, done, expired, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_borrow();
    test_expiry();
    test_pause_collision();
    test_sanitize();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Presettable BCD down-counter for the stopwatch/timer project. It is the decrementing counterpart of the BCD up-counting block. Its count output uses the same packed BCD format, one digit per nibble with the least significant digit in bits [3:0], so it drives the existing seven-segment decode path unchanged. A start/stop pulse controls it, an external tick enable paces it, and it flags expiry when it reaches zero.

Parameters:
- DIGITS, 4, number of BCD digits; count width is 4*DIGITS (16 by default).

Ports:
- clk  input  1  system clock; all state changes on posedge clk.
- reset  input  1  synchronous, active-low reset; sampled only on posedge clk.
- load  input  1  when high, preset the count from load_val.
- load_val  input  4*DIGITS  packed BCD preset value.
- start_stop  input  1  single-cycle control pulse (run/pause/acknowledge).
- tick  input  1  count enable from the prescaler; one decrement per high cycle while running.
- count  output  4*DIGITS  current packed BCD value.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE (count is zero after expiry).
- expired  output  1  one-cycle pulse on the edge that enters DONE.

Behaviour:
- All outputs are registered. Every input is sampled at posedge clk.
- Priority per edge: reset, then load, then start_stop, then tick.
- Reset (reset==0 at posedge clk):
  - count=0, reload register=0, state=IDLE.
  - running=0, done=0, expired=0.
  - Applies mid-count with no residual state.
- States: IDLE, RUN, PAUSED, DONE. running is 1 only in RUN; done is 1 only in DONE.
- Load (any state):
  - count <= sanitized load_val; reload register <= the same value.
  - State goes to IDLE; expired=0.
  - Sanitize rule: any nibble greater than 9 is clamped to 9, independently per digit.
- start_stop, same edge:
  - IDLE with count!=0 -> RUN.
  - IDLE with count==0 -> no effect, stays IDLE.
  - RUN -> PAUSED.
  - PAUSED -> RUN.
  - DONE -> IDLE, and count <= reload register.
- tick in RUN with no start_stop: BCD decrement by 1.
  - Digit 0 becomes 9 and borrows from the next digit up.
  - Digits 1-9 decrement with no borrow.
- Reaching zero: if the pre-decrement count is 0...01, then on that edge count becomes 0, state becomes DONE, expired=1 for exactly one cycle, and running drops.
- In RUN, count is never 0; no wrap past zero is ever permitted.
- tick is ignored in IDLE, PAUSED and DONE: count holds.
- tick and start_stop in the same cycle while in RUN: pause wins and no decrement occurs.
- Latency: one clock from the tick edge to the updated count; no pipelining.
- Back-to-back ticks (tick held high) decrement once per clock.
- load_val is only observed when load is high.

Test Plan:
- Borrow across digits: reset, load 0x0102, start_stop, 3 ticks -> count 0x0101, 0x0100, 0x0099; running=1.
- Multi-digit borrow: load 0x1000, start, 1 tick -> 0x0999. Load 0x0000 then start_stop -> stays IDLE, running=0.
- Expiry: load 0x0001, start, tick -> count 0x0000, expired high for exactly 1 cycle, done=1, running=0. Further ticks leave 0x0000. start_stop -> count 0x0001, IDLE.
- Pause and collision: load 0x0050, start, tick held high together with start_stop -> count stays 0x0050, PAUSED. Ticks while PAUSED leave 0x0050. start_stop then tick -> 0x0049.
- Sanitize and load priority: load_val 0xA5F3 with load=1 while RUN, tick=1 and start_stop=1 -> count 0x9593, IDLE, running=0.
- Reset mid-run: load 0x0300, start, 5 ticks (0x0295), reset low one edge -> count 0, all flags 0. start_stop afterwards -> stays IDLE.
